// File: rtl/wordmem.sv
// wordmem: single-port DEPTH x WIDTH word memory with registered read, valid strobe
// and a post-reset clear sweep. Define WORDMEM_PARITY_EN to store and check even parity.
module wordmem #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  inp,
    output logic [WIDTH-1:0]  outp,
    output logic              outp_valid,
    output logic              busy,
    output logic              err
);

`ifdef WORDMEM_PARITY_EN
    localparam int MEM_W = WIDTH + 1;
`else
    localparam int MEM_W = WIDTH;
`endif

    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] IDLE  = 1'b1;

    // DEPTH fits in ADDR_W+1 bits because 2**ADDR_W >= DEPTH.
    localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    logic [MEM_W-1:0]  mem_q [DEPTH];
    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0]  outp_q, outp_d;
    logic              outp_valid_q, outp_valid_d;
    logic              err_q, err_d;

    logic              in_range;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_idx;
    logic [MEM_W-1:0]  wr_word;
    logic [MEM_W-1:0]  rd_word;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        outp_d       = outp_q;
        outp_valid_d = 1'b0;
        err_d        = 1'b0;
        wr_en        = 1'b0;
        wr_idx       = addr;
`ifdef WORDMEM_PARITY_EN
        wr_word      = {^inp, inp};
`else
        wr_word      = inp;
`endif
        in_range     = ({1'b0, addr} < DEPTH_W);
        rd_word      = '0;
        if (!rst) begin
            if (state_q == CLEAR) begin
                wr_en   = 1'b1;
                wr_idx  = ptr_q;
                wr_word = '0;
                if (ptr_q == LAST) begin
                    state_d = IDLE;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end else if (sel) begin
                if (op) begin
                    // Out-of-range writes are silently dropped.
                    wr_en = in_range;
                end else begin
                    outp_valid_d = 1'b1;
                    if (in_range) begin
                        rd_word = mem_q[addr];
                        outp_d  = rd_word[WIDTH-1:0];
`ifdef WORDMEM_PARITY_EN
                        err_d   = rd_word[WIDTH] ^ (^rd_word[WIDTH-1:0]);
`endif
                    end else begin
                        outp_d = '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= CLEAR;
            ptr_q        <= '0;
            outp_q       <= '0;
            outp_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            outp_q       <= outp_d;
            outp_valid_q <= outp_valid_d;
            err_q        <= err_d;
        end
    end

    // Storage is not reset; the sweep is the only way it gets cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_word;
        end
    end

    assign outp       = outp_q;
    assign outp_valid = outp_valid_q;
    assign busy       = (state_q == CLEAR);
    assign err        = err_q;

endmodule

// File: tb/tb_wordmem.sv
// tb_wordmem: drives a DEPTH=8 and a DEPTH=5 wordmem with shared stimulus and
// checks both every cycle against a word-array model with a busy countdown.
module tb_wordmem;
    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, sel, op;
    logic [2:0] addr;
    logic [7:0] inp;
    logic [7:0] outp8, outp5;
    logic       v8, v5, b8, b5, e8, e5;

    wordmem #(.WIDTH(8), .DEPTH(8), .ADDR_W(3)) u8 (
        .clk(clk), .rst(rst), .sel(sel), .op(op), .addr(addr), .inp(inp),
        .outp(outp8), .outp_valid(v8), .busy(b8), .err(e8)
    );

    wordmem #(.WIDTH(8), .DEPTH(5), .ADDR_W(3)) u5 (
        .clk(clk), .rst(rst), .sel(sel), .op(op), .addr(addr), .inp(inp),
        .outp(outp5), .outp_valid(v5), .busy(b5), .err(e5)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: per instance a word array, a countdown of sweep cycles left,
    // and the expected registered outputs.
    int         dep [2] = '{8, 5};
    logic [7:0] mm [2][8];
    int         busy_rem [2];
    logic [7:0] e_out [2];
    logic       e_v [2];
    logic       e_err [2];
    bit         known = 0;
    bit         corrupt0 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            e_v[k]   = 1'b0;
            e_err[k] = 1'b0;
            if (rst) begin
                known       = 1;
                busy_rem[k] = dep[k];
                e_out[k]    = 8'h00;
                for (int j = 0; j < 8; j++) mm[k][j] = 8'h00;
                if (k == 0) corrupt0 = 0;
            end else if (busy_rem[k] > 0) begin
                busy_rem[k]--;
            end else if (sel && op) begin
                if (int'(addr) < dep[k]) begin
                    mm[k][addr] = inp;
                    if (k == 0 && addr == 3'd0) corrupt0 = 0;
                end
            end else if (sel) begin
                e_v[k]   = 1'b1;
                e_out[k] = (int'(addr) < dep[k]) ? mm[k][addr] : 8'h00;
                e_err[k] = (k == 0) && corrupt0 && (addr == 3'd0);
            end
        end
    endtask

    task automatic compare();
        if (known) begin
            chk("outp8", outp8, e_out[0]);
            chk("valid8", v8, e_v[0]);
            chk("busy8", b8, busy_rem[0] > 0);
            chk("err8", e8, e_err[0]);
            chk("outp5", outp5, e_out[1]);
            chk("valid5", v5, e_v[1]);
            chk("busy5", b5, busy_rem[1] > 0);
            chk("err5", e5, e_err[1]);
        end
    endtask

    task automatic drive(input bit r, input bit s, input bit o, input int a, input logic [7:0] d);
        rst  = r;
        sel  = s;
        op   = o;
        addr = a[2:0];
        inp  = d;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((b8 || b5) && n < 20) begin
            drive(0, 0, 0, 0, 8'h00);
            n++;
        end
        chk("idle_timeout", {31'd0, b8 | b5}, 32'd0);
    endtask

    initial begin
        int n8, n5;
        rst = 1'b1; sel = 1'b0; op = 1'b0; addr = '0; inp = '0;
        @(negedge clk);

        // Reset held two cycles, then measure sweep length; a write mid-sweep is ignored.
        drive(1, 0, 0, 0, 8'h00);
        drive(1, 0, 0, 0, 8'h00);
        chk("busy_after_rst", {31'd0, b8}, 32'd1);
        n8 = 0;
        n5 = 0;
        while (b8 && n8 < 20) begin
            if (n8 == 2) drive(0, 1, 1, 2, 8'hFF);
            else         drive(0, 0, 0, 0, 8'h00);
            n8++;
            if (!b5 && n5 == 0) n5 = n8;
        end
        chk("busy_len8", n8, 8);
        chk("busy_len5", n5, 5);
        wait_idle();

        for (int a = 0; a < 8; a++) drive(0, 1, 0, a, 8'h00);
        drive(0, 0, 0, 0, 8'h00);

        drive(0, 1, 1, 3, 8'hA5);
        drive(0, 1, 1, 7, 8'h3C);
        drive(0, 1, 0, 3, 8'h00);
        chk("rd3_a", outp8, 8'hA5);
        drive(0, 1, 0, 7, 8'h00);
        chk("rd7", outp8, 8'h3C);
        drive(0, 1, 0, 3, 8'h00);
        chk("rd3_b", outp8, 8'hA5);
        drive(0, 0, 0, 0, 8'h00);
        chk("hold_outp", outp8, 8'hA5);
        drive(0, 1, 0, 2, 8'h00);
        chk("rd2_ignored_wr", outp8, 8'h00);

        // Read in flight when reset arrives.
        drive(0, 1, 1, 1, 8'h11);
        drive(0, 1, 0, 1, 8'h00);
        chk("rd1_pre_rst", outp8, 8'h11);
        drive(1, 1, 0, 1, 8'h00);
        chk("valid_killed", {31'd0, v8}, 32'd0);
        chk("outp_rst", outp8, 8'h00);
        wait_idle();
        drive(0, 1, 0, 1, 8'h00);
        chk("rd1_post_rst", outp8, 8'h00);

        // Out-of-range access on the DEPTH=5 instance.
        drive(0, 1, 1, 6, 8'h77);
        drive(0, 1, 0, 6, 8'h00);
        chk("oor_out5", outp5, 8'h00);
        chk("oor_v5", {31'd0, v5}, 32'd1);
        drive(0, 1, 1, 4, 8'h42);
        drive(0, 1, 0, 4, 8'h00);
        chk("rd4_5", outp5, 8'h42);

`ifdef WORDMEM_PARITY_EN
        drive(0, 1, 1, 0, 8'h81);
        u8.mem_q[0][8] = 1'b1;
        corrupt0 = 1;
        drive(0, 1, 0, 0, 8'h00);
        chk("par_err", {31'd0, e8}, 32'd1);
        drive(0, 1, 0, 4, 8'h00);
        chk("par_ok", {31'd0, e8}, 32'd0);
`endif

        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 63) == 0), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)), 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wordmem.md
Name: wordmem

Overview:
Parametrised single-port synchronous word memory; successor to the 8x8 bytecell array.
- Generalises to DEPTH words of WIDTH bits, with address decode inside the block.
- Adds a registered read with a valid strobe, and a hardware clear sweep after reset with a busy indication.
- Sits under the top-level memory controller and keeps the team's sel/op request convention: op=1 write, op=0 read.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 8, number of words (>=2; need not be a power of two)
ADDR_W, 3, address width; must satisfy 2**ADDR_W >= DEPTH

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
sel  input  1  request valid for this memory this cycle
op  input  1  operation: 1 = write, 0 = read
addr  input  ADDR_W  word address
inp  input  WIDTH  write data
outp  output  WIDTH  registered read data
outp_valid  output  1  one-cycle strobe: outp updated by a read this cycle
busy  output  1  clear sweep in progress; requests ignored
err  output  1  parity error on the current read (see Optional Feature)

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values, taking effect at the edge where rst=1: outp=0, outp_valid=0, busy=1, err=0, state=CLEAR, sweep pointer=0.
- Storage contents are not reset directly; they are cleared by the sweep.
- Two states: CLEAR and IDLE.
- CLEAR:
  - Each cycle writes 0 to mem[ptr], then ptr increments.
  - After the edge that writes ptr=DEPTH-1, state becomes IDLE and busy drops to 0.
  - busy is therefore high for exactly DEPTH cycles after the first edge with rst=0.
  - sel, op, addr and inp are ignored; no write and no outp_valid.
- IDLE, write (sel=1, op=1):
  - mem[addr] <= inp at the edge.
  - outp holds its value; outp_valid=0.
- IDLE, read (sel=1, op=0):
  - At the edge, outp <= mem[addr] and outp_valid=1 for the following cycle.
  - Latency: 1 cycle from request edge to data.
  - Back-to-back reads give one valid per cycle.
- IDLE, sel=0: no access; outp holds its last value; outp_valid=0.
- Write followed by a read of the same address on the next cycle returns the newly written data. No bypass is needed: a single port and registered read make this inherent.
- Out-of-range address (addr >= DEPTH, possible only when DEPTH is not a power of two):
  - Write is dropped; no storage changes.
  - Read returns outp=0 with outp_valid=1 and err=0.
- rst=1 in any cycle, including mid-sweep or with a read in flight:
  - Overrides sel.
  - The pending outp_valid is suppressed.
  - Sweep restarts from ptr=0 on the next cycle; no partial state survives.
- The sweep pointer width is ADDR_W. The CLEAR terminal compare is against DEPTH-1, not wrap-around.

Optional Feature:
WORDMEM_PARITY_EN
- Defined:
  - Each word stores WIDTH+1 bits; the extra bit is even parity of inp, computed on write.
  - The CLEAR sweep writes parity 0.
  - On a read, err=1 in the same cycle as outp_valid if the stored parity mismatches the XOR of the stored data; otherwise err=0.
  - err is never asserted without outp_valid.
- Undefined: storage is WIDTH bits; err is tied to 0. Port list is identical in both builds.

Test Plan:
- Reset/clear, WIDTH=8 DEPTH=8: rst high 2 cycles, then low -> busy=1 for exactly 8 cycles then 0; reads of addr 0..7 each return 0x00 with outp_valid one cycle after request.
- Write/read: write 0xA5@3, 0x3C@7, then read 3, 7, 3 back-to-back -> outp = 0xA5, 0x3C, 0xA5 on consecutive cycles, outp_valid high 3 cycles.
- Ignore while busy: issue write 0xFF@2 during the sweep; after busy=0, read 2 -> 0x00.
- Mid-operation reset: write 0x11@1, request read 1, assert rst on the next cycle -> outp_valid stays 0, outp=0, busy=1 for 8 cycles after release; read 1 -> 0x00.
- Non-power-of-two, DEPTH=5 ADDR_W=3: write 0x77@6, read 6 -> outp=0x00, outp_valid=1; read 4 after write 0x42@4 -> 0x42.
- WORDMEM_PARITY_EN: write 0x81@0, force the stored parity bit to 1 via hierarchy, read 0 -> outp=0x81, outp_valid=1, err=1; an unforced word reads with err=0.
